// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit-side controllers.
// Frame-time helper sizes timeouts against a baud rate.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int UART_DATA_W        = 8;
    localparam int DEF_TIMEOUT_CYCLES = 131072;

    // 8N1 frame is 10 bit times; rounded to the nearest clock.
    function automatic int frame_cycles_9600(input longint clk_hz);
        longint c;
        c = (clk_hz * 10 + 4800) / 9600;
        return int'(c);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector with a lock override.
// Lowest index at or above ptr (modulo N) wins.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         lock_en,
    input  logic [W-1:0] lock_id,
    output logic         any,
    output logic [W-1:0] win
);

    int idx;

    always_comb begin
        any = 1'b0;
        win = '0;
        idx = 0;
        if (lock_en) begin
            any = req[lock_id];
            win = lock_id;
        end else begin
            // Walk downward so the closest candidate is assigned last.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (req[idx]) begin
                    any = 1'b1;
                    win = W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among byte producers,
// with burst locking and a tx_done / next-byte timeout.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = UART_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GNT_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [GNT_W-1:0]          grant_id,
    output logic                      timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state, state_n;
    logic [GNT_W-1:0]   rr_ptr, rr_ptr_n;
    logic [GNT_W-1:0]   grant_q, grant_n;
    logic               lock, lock_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DATA_W-1:0]  data_q, data_n;
    logic [NUM_REQ-1:0] ready_int;
    logic               start_int;
    logic               err_int;
    logic               pick_any;
    logic [GNT_W-1:0]   pick_win;
    logic               terminal;
    logic [GNT_W-1:0]   next_id;

    rr_pick #(
        .N (NUM_REQ),
        .W (GNT_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .lock_en (lock),
        .lock_id (grant_q),
        .any     (pick_any),
        .win     (pick_win)
    );

    assign terminal = (cnt == TERM);
    assign next_id  = (grant_q == GNT_W'(NUM_REQ - 1)) ?
                      '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ARB;
            rr_ptr  <= '0;
            grant_q <= '0;
            lock    <= 1'b0;
            cnt     <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_n;
            rr_ptr  <= rr_ptr_n;
            grant_q <= grant_n;
            lock    <= lock_n;
            cnt     <= cnt_n;
            data_q  <= data_n;
        end
    end

    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        grant_n   = grant_q;
        lock_n    = lock;
        cnt_n     = cnt;
        data_n    = data_q;
        ready_int = '0;
        start_int = 1'b0;
        err_int   = 1'b0;
        unique case (state)
            ARB: begin
                if (pick_any) begin
                    ready_int[pick_win] = 1'b1;
                    data_n  = req_data[int'(pick_win)*DATA_W +: DATA_W];
                    grant_n = pick_win;
                    lock_n  = ~req_last[pick_win];
                    state_n = START;
                end else if (lock) begin
                    if (terminal) begin
                        err_int  = 1'b1;
                        lock_n   = 1'b0;
                        rr_ptr_n = next_id;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            START: begin
                start_int = 1'b1;
                cnt_n     = '0;
                state_n   = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done has priority over a coincident terminal count.
                if (tx_done) begin
                    cnt_n   = '0;
                    state_n = ARB;
                    if (!lock) rr_ptr_n = next_id;
                end else if (terminal) begin
                    err_int  = 1'b1;
                    lock_n   = 1'b0;
                    rr_ptr_n = next_id;
                    cnt_n    = '0;
                    state_n  = ARB;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ARB;
        endcase
    end

    // Ready is combinational from req_valid, so mask it while in reset.
    assign req_ready   = ready_int & {NUM_REQ{reset_n}};
    assign tx_start    = start_int;
    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign timeout_err = err_int;
    assign busy        = (state != ARB) | lock;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a mock transmitter.
// Short timeout keeps the abort scenarios brief.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    localparam logic [7:0] B_DATA [5] = '{8'hA0, 8'hA1, 8'hA2, 8'h33, 8'h00};
    localparam int         B_ID   [5] = '{1, 1, 1, 3, 0};

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic         tx_done;
    logic         busy;
    logic [1:0]   grant_id;
    logic         timeout_err;

    int errors;
    int checks;
    int done_delay;
    int cyc = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: done pulse done_delay cycles after start; 0 = never.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && done_delay != 0) begin
                repeat (done_delay) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] d,
                            input logic l);
        req_data[i*8 +: 8] = d;
        req_last[i] = l;
    endtask

    task automatic wait_ready(input int lim, output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < lim; i++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < lim; i++) begin
            if (!busy && !tx_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic apply_reset();
        req_valid = '0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_last = '1;
        reset_n = 1'b0;
        #2;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        checks++;
        if ({tx_start, busy, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: start/busy/err got %b want 000",
                     {tx_start, busy, timeout_err});
        end
        checks++;
        if (tx_data !== 8'h00 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: data %h gnt %0d want 00 0",
                     tx_data, grant_id);
        end
        step();
        req_valid = '0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        done_delay = 40;
        set_byte(2, 8'h41, 1'b1);
        req_valid = 4'b0100;
        wait_ready(10, ok);
        checks++;
        if (!ok || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h41 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL single_start: start %b data %h gnt %0d want 1 41 2",
                     tx_start, tx_data, grant_id);
        end
        step();
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait: start %b busy %b want 0 1",
                     tx_start, busy);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_done: busy %b want 0 after tx_done", busy);
        end
        set_byte(0, 8'h01, 1'b1);
        set_byte(3, 8'h03, 1'b1);
        req_valid = 4'b1001;
        wait_ready(10, ok);
        checks++;
        if (!ok || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL single_rrptr: got %b want 1000", req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (tx_data !== 8'h03) begin
            errors++;
            $display("FAIL single_data3: got %h want 03", tx_data);
        end
        wait_idle(200, ok);
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp;
        int prev;
        apply_reset();
        done_delay = 40;
        for (int i = 0; i < N; i++) set_byte(i, 8'h10 + 8'(i), 1'b1);
        req_valid = 4'hF;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            exp = g % 4;
            wait_ready(100, ok);
            checks++;
            if (!ok || req_ready !== 4'(1 << exp)) begin
                errors++;
                $display("FAIL rr_ready%0d: got %b want %b",
                         g, req_ready, 4'(1 << exp));
            end
            step();
            if (g == 4) req_valid = '0;
            checks++;
            if (tx_start !== 1'b1 || tx_data !== 8'h10 + 8'(exp) ||
                grant_id !== 2'(exp)) begin
                errors++;
                $display("FAIL rr_grant%0d: data %h gnt %0d want %h %0d",
                         g, tx_data, grant_id, 8'h10 + 8'(exp), exp);
            end
            if (g > 0) begin
                checks++;
                if (cyc - prev !== 42) begin
                    errors++;
                    $display("FAIL rr_gap%0d: got %0d want 42",
                             g, cyc - prev);
                end
            end
            prev = cyc;
        end
        wait_idle(200, ok);
    endtask

    task automatic test_burst();
        bit ok;
        set_byte(1, 8'hA0, 1'b0);
        set_byte(0, 8'h00, 1'b1);
        set_byte(3, 8'h33, 1'b1);
        req_valid = 4'b1011;
        for (int g = 0; g < 5; g++) begin
            wait_ready(100, ok);
            checks++;
            if (!ok || req_ready !== 4'(1 << B_ID[g])) begin
                errors++;
                $display("FAIL burst_ready%0d: got %b want %b",
                         g, req_ready, 4'(1 << B_ID[g]));
            end
            if (g == 1 || g == 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_lockbusy%0d: got %b want 1",
                             g, busy);
                end
            end
            step();
            checks++;
            if (tx_data !== B_DATA[g] || grant_id !== 2'(B_ID[g])) begin
                errors++;
                $display("FAIL burst_grant%0d: data %h gnt %0d want %h %0d",
                         g, tx_data, grant_id, B_DATA[g], B_ID[g]);
            end
            case (g)
                0: set_byte(1, 8'hA1, 1'b0);
                1: set_byte(1, 8'hA2, 1'b1);
                2: req_valid[1] = 1'b0;
                3: req_valid[3] = 1'b0;
                default: req_valid[0] = 1'b0;
            endcase
        end
        wait_idle(200, ok);
    endtask

    task automatic test_timeout();
        bit ok;
        bit early;
        apply_reset();
        done_delay = 0;
        set_byte(2, 8'h55, 1'b1);
        set_byte(3, 8'h03, 1'b1);
        set_byte(0, 8'h01, 1'b1);
        req_valid = 4'b0100;
        wait_ready(10, ok);
        step();
        req_valid = 4'b1001;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55) begin
            errors++;
            $display("FAIL to_start: start %b data %h want 1 55",
                     tx_start, tx_data);
        end
        early = 1'b0;
        for (int j = 1; j < 64; j++) begin
            step();
            early |= timeout_err;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL to_early: got pulse want none before 64");
        end
        step();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: err %b busy %b want 1 1",
                     timeout_err, busy);
        end
        done_delay = 40;
        step();
        checks++;
        if (timeout_err !== 1'b0 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL to_next: err %b ready %b want 0 1000",
                     timeout_err, req_ready);
        end
        step();
        req_valid = '0;
        checks++;
        if (tx_data !== 8'h03 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL to_served: data %h gnt %0d want 03 3",
                     tx_data, grant_id);
        end
        wait_idle(200, ok);
    endtask

    task automatic test_lock_timeout();
        bit ok;
        bit bad;
        apply_reset();
        done_delay = 10;
        set_byte(1, 8'hB0, 1'b0);
        set_byte(2, 8'hC0, 1'b1);
        req_valid = 4'b0110;
        wait_ready(10, ok);
        checks++;
        if (!ok || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL lk_ready: got %b want 0010", req_ready);
        end
        step();
        req_valid = 4'b0100;
        bad = 1'b0;
        for (int j = 1; j < 74; j++) begin
            step();
            bad |= timeout_err | (req_ready != '0);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL lk_hold: got early pulse or grant want none");
        end
        step();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lk_pulse: err %b busy %b want 1 1",
                     timeout_err, busy);
        end
        step();
        checks++;
        if (req_ready !== 4'b0100 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL lk_release: ready %b err %b want 0100 0",
                     req_ready, timeout_err);
        end
        step();
        req_valid = '0;
        checks++;
        if (tx_data !== 8'hC0 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL lk_next: data %h gnt %0d want C0 2",
                     tx_data, grant_id);
        end
        wait_idle(200, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        done_delay = 0;
        set_byte(2, 8'h5A, 1'b1);
        req_valid = 4'b0100;
        wait_ready(10, ok);
        step();
        req_valid = '0;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd2 || tx_data !== 8'h5A) begin
            errors++;
            $display("FAIL mid_pre: busy %b gnt %0d data %h want 1 2 5A",
                     busy, grant_id, tx_data);
        end
        req_valid = 4'b1100;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, tx_start, timeout_err} !== 3'b000 ||
            req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_flags: bst/st/err %b ready %b want 000 0000",
                     {busy, tx_start, timeout_err}, req_ready);
        end
        checks++;
        if (grant_id !== 2'd0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_regs: gnt %0d data %h want 0 00",
                     grant_id, tx_data);
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_byte(i, 8'h20 + 8'(i), 1'b1);
        req_valid = 4'hF;
        done_delay = 40;
        wait_ready(10, ok);
        checks++;
        if (!ok || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_restart: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        wait_idle(200, ok);
    endtask

    task automatic test_coincident();
        bit ok;
        bit bad;
        apply_reset();
        done_delay = 64;
        set_byte(1, 8'h77, 1'b1);
        req_valid = 4'b0010;
        wait_ready(10, ok);
        step();
        req_valid = '0;
        bad = 1'b0;
        for (int j = 1; j <= 64; j++) begin
            step();
            bad |= timeout_err;
        end
        checks++;
        if (bad || tx_done !== 1'b1) begin
            errors++;
            $display("FAIL co_err: err seen %b done %b want 0 1",
                     bad, tx_done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL co_after: busy %b err %b want 0 0",
                     busy, timeout_err);
        end
        done_delay = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        done_delay = 0;
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_timeout();
        test_lock_timeout();
        test_reset_mid();
        test_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
